// File: rtl/dutb_fail_mon_pkg.sv
// Shared types and defaults for the dutb fail monitor.
package dutb_fail_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } mon_state_t;

  // Mirrors the framework-wide stop-on-fail default.
  localparam int unsigned DEF_MAX_FAIL_NUM = 16;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_CNT_WIDTH    = 16;

endpackage

// File: rtl/dutb_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over inc.
module dutb_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dutb_fail_monitor.sv
// Hardware-side result checker: compares masked transactions, counts
// pass/fail, reports each failure and stops the stream on fail budget.
module dutb_fail_monitor
  import dutb_fail_mon_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned P_MAX_FAIL_NUM = DEF_MAX_FAIL_NUM,
  parameter int unsigned P_CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [P_DATA_WIDTH-1:0] s_dout,
  input  logic [P_DATA_WIDTH-1:0] s_dexp,
  input  logic [P_DATA_WIDTH-1:0] s_mask,
  output logic [P_CNT_WIDTH-1:0]  txn_cnt,
  output logic [P_CNT_WIDTH-1:0]  pass_cnt,
  output logic [P_CNT_WIDTH-1:0]  fail_cnt,
  output logic                    fail_valid,
  output logic [P_CNT_WIDTH-1:0]  fail_index,
  output logic [P_DATA_WIDTH-1:0] fail_diff,
  output logic                    stop,
  output logic [1:0]              state
);

  // A budget that fail_cnt can never reach disables stopping entirely.
  localparam longint unsigned CNT_MAX = (64'd1 << P_CNT_WIDTH) - 64'd1;
  localparam bit STOP_EN = (P_MAX_FAIL_NUM != 0) &&
                           (longint'(P_MAX_FAIL_NUM) <= CNT_MAX);
  localparam int unsigned STOP_AT_INT = STOP_EN ? (P_MAX_FAIL_NUM - 1) : 0;
  localparam logic [P_CNT_WIDTH-1:0] STOP_AT = P_CNT_WIDTH'(STOP_AT_INT);

  mon_state_t state_q, state_d;
  logic                    fail_valid_q, fail_valid_d;
  logic [P_CNT_WIDTH-1:0]  fail_index_q, fail_index_d;
  logic [P_DATA_WIDTH-1:0] fail_diff_q, fail_diff_d;

  logic [P_DATA_WIDTH-1:0] diff;
  logic                    fail_hit;
  logic                    accept;
  logic                    cnt_clr;

  assign s_ready  = (state_q == RUN);
  assign diff     = (s_dout ^ s_dexp) & s_mask;
  assign fail_hit = |diff;
  // clear drops a same-cycle handshake.
  assign accept   = s_valid && s_ready && !clear;
  assign cnt_clr  = rst || clear;

  dutb_sat_counter #(.WIDTH(P_CNT_WIDTH)) u_txn_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (accept),
    .cnt (txn_cnt)
  );

  dutb_sat_counter #(.WIDTH(P_CNT_WIDTH)) u_pass_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (accept && !fail_hit),
    .cnt (pass_cnt)
  );

  dutb_sat_counter #(.WIDTH(P_CNT_WIDTH)) u_fail_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (accept && fail_hit),
    .cnt (fail_cnt)
  );

  always_comb begin
    state_d      = state_q;
    fail_valid_d = 1'b0;
    fail_index_d = fail_index_q;
    fail_diff_d  = fail_diff_q;

    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (accept && fail_hit && STOP_EN && (fail_cnt == STOP_AT)) begin
          state_d = STOP;
        end
      end
      STOP: state_d = STOP;
      default: state_d = IDLE;
    endcase

    if (accept && fail_hit) begin
      fail_valid_d = 1'b1;
      fail_index_d = txn_cnt;
      fail_diff_d  = diff;
    end

    if (clear) begin
      state_d      = IDLE;
      fail_valid_d = 1'b0;
      fail_index_d = '0;
      fail_diff_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fail_valid_q <= 1'b0;
      fail_index_q <= '0;
      fail_diff_q  <= '0;
    end else begin
      state_q      <= state_d;
      fail_valid_q <= fail_valid_d;
      fail_index_q <= fail_index_d;
      fail_diff_q  <= fail_diff_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_index = fail_index_q;
  assign fail_diff  = fail_diff_q;
  assign stop       = (state_q == STOP);
  assign state      = state_q;

endmodule

// File: tb/tb_dutb_fail_monitor.sv
// Directed bench for dutb_fail_monitor with a fail budget of 4.
module tb_dutb_fail_monitor;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, clear, s_valid;
  logic          s_ready;
  logic [DW-1:0] s_dout, s_dexp, s_mask;
  logic [CW-1:0] txn_cnt, pass_cnt, fail_cnt, fail_index;
  logic          fail_valid, stop;
  logic [DW-1:0] fail_diff;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dutb_fail_monitor #(
    .P_DATA_WIDTH   (DW),
    .P_MAX_FAIL_NUM (4),
    .P_CNT_WIDTH    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_dout     (s_dout),
    .s_dexp     (s_dexp),
    .s_mask     (s_mask),
    .txn_cnt    (txn_cnt),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .fail_valid (fail_valid),
    .fail_index (fail_index),
    .fail_diff  (fail_diff),
    .stop       (stop),
    .state      (state)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_and_start();
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; s_valid = 1'b0;
    s_dout = '0; s_dexp = '0; s_mask = '0;
    repeat (3) step();
    rst = 1'b0;
    checks++;
    if (fail_valid !== 1'b0 || stop !== 1'b0 || fail_index !== '0 || fail_diff !== '0) begin
      errors++;
      $display("FAIL reset_outputs: fail_valid=%b stop=%b fail_index=%0d fail_diff=%h, required 0 0 0 0",
               fail_valid, stop, fail_index, fail_diff);
    end
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (s_ready !== 1'b0 || state !== 2'd0 || txn_cnt !== '0 || pass_cnt !== '0 || fail_cnt !== '0) begin
        errors++;
        $display("FAIL idle_ignore[%0d]: s_ready=%b state=%0d txn=%0d pass=%0d fail=%0d, required 0 0 0 0 0",
                 i, s_ready, state, txn_cnt, pass_cnt, fail_cnt);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_pass_stream();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (state !== 2'd1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_run: state=%0d s_ready=%b, required 1 1", state, s_ready);
    end
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_dout  = 32'hA5A5_0000 + i;
      s_dexp  = 32'hA5A5_0000 + i;
      s_mask  = '1;
      step();
      checks++;
      if (fail_valid !== 1'b0 || txn_cnt !== CW'(i + 1)) begin
        errors++;
        $display("FAIL pass_stream[%0d]: fail_valid=%b txn=%0d, required 0 %0d", i, fail_valid, txn_cnt, i + 1);
      end
    end
    s_valid = 1'b0;
    step();
    checks++;
    if (txn_cnt !== 16'd8 || pass_cnt !== 16'd8 || fail_cnt !== 16'd0 || fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_totals: txn=%0d pass=%0d fail=%0d fv=%b, required 8 8 0 0",
               txn_cnt, pass_cnt, fail_cnt, fail_valid);
    end
  endtask

  task automatic test_masked_fail();
    clear_and_start();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_dout = 32'h1234_0000 + i; s_dexp = 32'h1234_0000 + i; s_mask = '1;
      step();
    end
    s_dout = 32'h0000_00FF; s_dexp = 32'h0000_000F; s_mask = 32'h0000_00F0;
    step();
    checks++;
    if (fail_valid !== 1'b1 || fail_index !== 16'd2 || fail_diff !== 32'h0000_00F0 || fail_cnt !== 16'd1) begin
      errors++;
      $display("FAIL masked_fail: fv=%b idx=%0d diff=%h fail=%0d, required 1 2 000000f0 1",
               fail_valid, fail_index, fail_diff, fail_cnt);
    end
    s_mask = 32'h0000_000F;
    step();
    checks++;
    if (fail_valid !== 1'b0 || pass_cnt !== 16'd3 || fail_index !== 16'd2 || fail_diff !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL masked_pass_hold: fv=%b pass=%0d idx=%0d diff=%h, required 0 3 2 000000f0",
               fail_valid, pass_cnt, fail_index, fail_diff);
    end
    s_dout = 32'hFFFF_FFFF; s_dexp = 32'h0000_0000; s_mask = '0;
    step();
    s_valid = 1'b0;
    checks++;
    if (fail_valid !== 1'b0 || pass_cnt !== 16'd4 || fail_cnt !== 16'd1 || txn_cnt !== 16'd5) begin
      errors++;
      $display("FAIL zero_mask: fv=%b pass=%0d fail=%0d txn=%0d, required 0 4 1 5",
               fail_valid, pass_cnt, fail_cnt, txn_cnt);
    end
  endtask

  task automatic test_stop_budget();
    int exp_cnt;
    clear_and_start();
    s_valid = 1'b1; s_mask = '1;
    for (int k = 1; k <= 10; k++) begin
      s_dout = 32'h0000_0100 + k;
      s_dexp = ~(32'h0000_0100 + k);
      step();
      exp_cnt = (k < 4) ? k : 4;
      checks++;
      if (txn_cnt !== CW'(exp_cnt) || fail_cnt !== CW'(exp_cnt) || fail_valid !== (k <= 4) ||
          stop !== (k >= 4) || s_ready !== (k < 4)) begin
        errors++;
        $display("FAIL stop_budget[%0d]: txn=%0d fail=%0d fv=%b stop=%b rdy=%b, required %0d %0d %b %b %b",
                 k, txn_cnt, fail_cnt, fail_valid, stop, s_ready, exp_cnt, exp_cnt, k <= 4, k >= 4, k < 4);
      end
    end
    checks++;
    if (state !== 2'd2 || fail_index !== 16'd3 || pass_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stop_state: state=%0d idx=%0d pass=%0d, required 2 3 0", state, fail_index, pass_cnt);
    end
  endtask

  task automatic test_clear_priority();
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0; s_valid = 1'b0;
    checks++;
    if (state !== 2'd0 || stop !== 1'b0 || txn_cnt !== '0 || fail_cnt !== '0 || pass_cnt !== '0 ||
        fail_index !== '0 || fail_diff !== '0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio: state=%0d stop=%b txn=%0d fail=%0d pass=%0d idx=%0d diff=%h rdy=%b, required all 0",
               state, stop, txn_cnt, fail_cnt, pass_cnt, fail_index, fail_diff, s_ready);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (state !== 2'd1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart: state=%0d s_ready=%b, required 1 1", state, s_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_and_start();
    s_valid = 1'b1; s_dout = 32'hDEAD_BEEF; s_dexp = 32'h0; s_mask = '1;
    step();
    s_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (fail_valid !== 1'b0 || fail_cnt !== '0 || txn_cnt !== '0 || state !== 2'd0 || fail_diff !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: fv=%b fail=%0d txn=%0d state=%0d diff=%h, required 0 0 0 0 0",
               fail_valid, fail_cnt, txn_cnt, state, fail_diff);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fail_valid !== 1'b0 || state !== 2'd0) begin
        errors++;
        $display("FAIL reset_no_leak[%0d]: fv=%b state=%0d, required 0 0", i, fail_valid, state);
      end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_pass_stream();
    test_masked_fail();
    test_stop_budget();
    test_clear_priority();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
